instr_buffer: RTL and testbench
===============================

# instr_buffer

Decoupling FIFO between instruction fetch and decode/dispatch. Fetch pushes up to FETCH_WIDTH instructions per cycle. The buffer presents the oldest ISSUE_WIDTH entries to decode/dispatch as a first-word-fall-through window. Dispatch returns a per-slot accept mask, and accepted entries are popped in program order at the next clock edge. A flush empties the buffer in one cycle.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 4
- FETCH_WIDTH, 2, push lanes
- ISSUE_WIDTH, 2, output slots

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries
- fetch_valid_i  in  FETCH_WIDTH  per-lane push request
- fetch_pc_i  in  FETCH_WIDTH×32  lane PC
- fetch_instr_i  in  FETCH_WIDTH×32  lane instruction word
- fetch_excp_i  in  FETCH_WIDTH  lane carries fetch exception
- fetch_excp_num_i  in  FETCH_WIDTH×4  exception code
- fetch_ready_o  out  1  buffer can take a full fetch group this cycle
- id_valid_o  out  ISSUE_WIDTH  slot holds a valid entry
- id_pc_o, id_instr_o  out  ISSUE_WIDTH×32  slot payload
- id_excp_o  out  ISSUE_WIDTH  slot exception flag
- id_excp_num_o  out  ISSUE_WIDTH×4  slot exception code
- ib_accept_i  in  ISSUE_WIDTH  per-slot accept from dispatch
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_cycles_o, empty_cycles_o  out  32  performance counters (see Configuration)

## Operation
- Circular storage with head and tail pointers of $clog2(DEPTH) bits. Occupancy is a separate counter of $clog2(DEPTH)+1 bits.
- fetch_ready_o = (DEPTH − count) ≥ FETCH_WIDTH. It is computed from registered count only, so there is no combinational path from ib_accept_i.
- **Push:** occurs only when fetch_ready_o = 1.
  - Valid lanes are compacted in lane order into consecutive entries starting at tail. Example: fetch_valid_i = 2'b10 writes lane 1 at tail.
  - tail advances by popcount(fetch_valid_i).
  - When fetch_ready_o = 0, fetch_valid_i is ignored. Fetch must hold its group.
- **Output window:** slot k shows entry head+k, with wrap modulo DEPTH.
  - id_valid_o[k] = (count > k).
  - Slots that are not valid drive all-zero payload.
- **Pop:**
  - Pop count n = the number of leading ones of (ib_accept_i & id_valid_o), starting at slot 0.
  - A set bit that follows a cleared bit is ignored. Example: 2'b10 pops nothing.
  - head advances by n.
- **Simultaneous push and pop:** count_next = count + pushed − popped. Both may occur in the same cycle, including when count = DEPTH − FETCH_WIDTH.
- **Flush:** head, tail and count go to 0 at the next edge. Pushes and pops in the same cycle are discarded. Flush has priority over push and pop.
- **Reset:** same effect as flush. Reset has priority over flush.

## Timing
- Push-to-visible latency: 1 cycle. An entry pushed at edge N appears in the window after edge N; there is no same-cycle bypass.
- Pop takes effect at the edge. The next entries are visible in the following cycle.
- id_* outputs are combinational from registered storage and pointers.
- Flush-to-empty latency: 1 cycle. fetch_ready_o = 1 in the cycle after a flush.
- Reset values:
  - id_valid_o = 0, all id_* payload = 0
  - count_o = 0, fetch_ready_o = 1
  - full_cycles_o = 0, empty_cycles_o = 0
  - Storage contents are don't-care.

## Configuration
- INSTR_BUFFER_PERF_CNT_EN
  - Defined: full_cycles_o increments each cycle with fetch_ready_o = 0. empty_cycles_o increments each cycle with count = 0. Both saturate at 32'hFFFF_FFFF. Both clear on rst only, not on flush.
  - Undefined: both ports are tied to 0 and no counter registers are instantiated.

## Test plan
- **Reset and first push:** assert rst, then push lanes 11 with PC 0x1C000000/0x1C000004 and ib_accept_i = 00.
  - During reset: id_valid_o = 00, count_o = 0, fetch_ready_o = 1.
  - Next cycle: id_valid_o = 11, id_pc_o = {0x1C000004, 0x1C000000}, count_o = 2.
- **Partial and illegal accept:** from count 2, ib_accept_i = 01.
  - Next cycle: count_o = 1, slot0 PC = 0x1C000004, id_valid_o = 01.
  - ib_accept_i = 10 then pops nothing; count_o stays 1.
- **Compaction:** fetch_valid_i = 10 with an empty buffer. Next cycle: slot0 holds lane 1's PC and exception fields, id_valid_o = 01.
- **Full boundary:** fill to 7 → fetch_ready_o = 0; a held group is not written and count stays 7.
  - Same cycle, apply ib_accept_i = 11 → next cycle count_o = 5, fetch_ready_o = 1.
  - With pushes of 2 and pops of 2 in the same cycle at count 6 → count_o stays 6.
- **Wrap-around:** stream 40 sequential PCs with random accept masks. Popped order must equal pushed order, with no loss or duplication across pointer wrap.
- **Flush:** flush_i together with a valid push and ib_accept_i = 11 at count 5.
  - Next cycle: count_o = 0, id_valid_o = 00.
  - With INSTR_BUFFER_PERF_CNT_EN defined, empty_cycles_o increments from that cycle.

Source files
------------

// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode with a lane-compacting
// multi-push, an in-order multi-pop FWFT window and one-cycle flush. Optional perf
// counters are enabled by defining INSTR_BUFFER_PERF_CNT_EN.
module instr_buffer #(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [FETCH_WIDTH-1:0]       fetch_valid_i,
    input  logic [FETCH_WIDTH*32-1:0]    fetch_pc_i,
    input  logic [FETCH_WIDTH*32-1:0]    fetch_instr_i,
    input  logic [FETCH_WIDTH-1:0]       fetch_excp_i,
    input  logic [FETCH_WIDTH*4-1:0]     fetch_excp_num_i,
    output logic                         fetch_ready_o,
    output logic [ISSUE_WIDTH-1:0]       id_valid_o,
    output logic [ISSUE_WIDTH*32-1:0]    id_pc_o,
    output logic [ISSUE_WIDTH*32-1:0]    id_instr_o,
    output logic [ISSUE_WIDTH-1:0]       id_excp_o,
    output logic [ISSUE_WIDTH*4-1:0]     id_excp_num_o,
    input  logic [ISSUE_WIDTH-1:0]       ib_accept_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [31:0]                  full_cycles_o,
    output logic [31:0]                  empty_cycles_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_WIDTH);

    logic [31:0]      pc_mem       [DEPTH];
    logic [31:0]      instr_mem    [DEPTH];
    logic             excp_mem     [DEPTH];
    logic [3:0]       excp_num_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    logic [FETCH_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_idx [FETCH_WIDTH];

    // Ready depends only on registered occupancy, never on the accept mask.
    assign fetch_ready_o = (DEPTH_C - count) >= FETCH_C;
    assign count_o       = count;

    // Valid lanes are packed into consecutive slots starting at tail.
    always_comb begin
        push_n = '0;
        wr_en  = '0;
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            wr_idx[l] = tail + push_n[PTR_W-1:0];
            wr_en[l]  = fetch_ready_o & ~flush_i & fetch_valid_i[l];
            if (wr_en[l]) begin
                push_n = push_n + 1'b1;
            end
        end
    end

    always_comb begin
        id_valid_o    = '0;
        id_pc_o       = '0;
        id_instr_o    = '0;
        id_excp_o     = '0;
        id_excp_num_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (count > CNT_W'(k)) begin
                id_valid_o[k]           = 1'b1;
                id_pc_o[k*32 +: 32]     = pc_mem[head + PTR_W'(k)];
                id_instr_o[k*32 +: 32]  = instr_mem[head + PTR_W'(k)];
                id_excp_o[k]            = excp_mem[head + PTR_W'(k)];
                id_excp_num_o[k*4 +: 4] = excp_num_mem[head + PTR_W'(k)];
            end
        end
    end

    // Only the unbroken run of accepted slots from slot 0 is popped.
    always_comb begin
        logic run;
        pop_n = '0;
        run   = 1'b1;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (run && ib_accept_i[k] && id_valid_o[k]) begin
                pop_n = pop_n + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_n[PTR_W-1:0];
            tail  <= tail + push_n[PTR_W-1:0];
            count <= count + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (wr_en[l]) begin
                pc_mem[wr_idx[l]]       <= fetch_pc_i[l*32 +: 32];
                instr_mem[wr_idx[l]]    <= fetch_instr_i[l*32 +: 32];
                excp_mem[wr_idx[l]]     <= fetch_excp_i[l];
                excp_num_mem[wr_idx[l]] <= fetch_excp_num_i[l*4 +: 4];
            end
        end
    end

`ifdef INSTR_BUFFER_PERF_CNT_EN
    logic [31:0] full_cycles;
    logic [31:0] empty_cycles;

    // Saturating; cleared by reset only so flushes do not lose history.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles  <= '0;
            empty_cycles <= '0;
        end else begin
            if (!fetch_ready_o && (full_cycles != 32'hFFFF_FFFF)) begin
                full_cycles <= full_cycles + 32'd1;
            end
            if ((count == '0) && (empty_cycles != 32'hFFFF_FFFF)) begin
                empty_cycles <= empty_cycles + 32'd1;
            end
        end
    end

    assign full_cycles_o  = full_cycles;
    assign empty_cycles_o = empty_cycles;
`else
    assign full_cycles_o  = '0;
    assign empty_cycles_o = '0;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Directed and random-stream bench for instr_buffer; a queue of expected entries is
// compared against the output window every cycle.
module tb_instr_buffer;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int IW    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [3:0]  num;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic [FW-1:0]   fetch_valid_i;
    logic [FW*32-1:0] fetch_pc_i;
    logic [FW*32-1:0] fetch_instr_i;
    logic [FW-1:0]   fetch_excp_i;
    logic [FW*4-1:0] fetch_excp_num_i;
    logic            fetch_ready_o;
    logic [IW-1:0]   id_valid_o;
    logic [IW*32-1:0] id_pc_o;
    logic [IW*32-1:0] id_instr_o;
    logic [IW-1:0]   id_excp_o;
    logic [IW*4-1:0] id_excp_num_o;
    logic [IW-1:0]   ib_accept_i;
    logic [3:0]      count_o;
    logic [31:0]     full_cycles_o;
    logic [31:0]     empty_cycles_o;

    entry_t      exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          m_full    = 0;
    int          m_empty   = 0;
    logic [31:0] next_pc   = 32'h3000_0000;

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_instr_i    (fetch_instr_i),
        .fetch_excp_i     (fetch_excp_i),
        .fetch_excp_num_i (fetch_excp_num_i),
        .fetch_ready_o    (fetch_ready_o),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_excp_o        (id_excp_o),
        .id_excp_num_o    (id_excp_num_o),
        .ib_accept_i      (ib_accept_i),
        .count_o          (count_o),
        .full_cycles_o    (full_cycles_o),
        .empty_cycles_o   (empty_cycles_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t mk(input logic [31:0] pc, input logic ex, input logic [3:0] num);
        entry_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hA5A5_0000;
        e.excp  = ex;
        e.num   = num;
        return e;
    endfunction

    function automatic int lead_ones(input logic [IW-1:0] mask);
        int n = 0;
        for (int k = 0; k < IW; k++) begin
            if (!mask[k]) break;
            n++;
        end
        return n;
    endfunction

    task automatic check_window();
        entry_t got;
        for (int k = 0; k < IW; k++) begin
            got = {id_pc_o[k*32 +: 32], id_instr_o[k*32 +: 32], id_excp_o[k], id_excp_num_o[k*4 +: 4]};
            if (k < exp_q.size()) begin
                chk($sformatf("slot%0d_valid", k), 128'(id_valid_o[k]), 128'(1));
                chk($sformatf("slot%0d_payload", k), 128'(got), 128'(exp_q[k]));
            end else begin
                chk($sformatf("slot%0d_valid", k), 128'(id_valid_o[k]), 128'(0));
                chk($sformatf("slot%0d_zero_payload", k), 128'(got), 128'(0));
            end
        end
        chk("fetch_ready", 128'(fetch_ready_o), 128'((DEPTH - exp_q.size()) >= FW));
    endtask

    task automatic check_perf();
`ifdef INSTR_BUFFER_PERF_CNT_EN
        chk("full_cycles", 128'(full_cycles_o), 128'(m_full));
        chk("empty_cycles", 128'(empty_cycles_o), 128'(m_empty));
`else
        chk("full_cycles_tied", 128'(full_cycles_o), 128'(0));
        chk("empty_cycles_tied", 128'(empty_cycles_o), 128'(0));
`endif
    endtask

    task automatic do_cycle(input logic [FW-1:0] fv, input logic [31:0] pc0, input logic [31:0] pc1,
                            input logic [FW-1:0] ex, input logic [3:0] n0, input logic [3:0] n1,
                            input logic [IW-1:0] acc, input logic fl);
        int          m;
        int          n;
        logic        ready;
        logic [IW-1:0] vm;
        entry_t      lane [FW];
        fetch_valid_i    = fv;
        fetch_pc_i       = {pc1, pc0};
        fetch_instr_i    = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'hA5A5_0000};
        fetch_excp_i     = ex;
        fetch_excp_num_i = {n1, n0};
        ib_accept_i      = acc;
        flush_i          = fl;
        check_window();
        lane[0] = mk(pc0, ex[0], n0);
        lane[1] = mk(pc1, ex[1], n1);
        m     = exp_q.size();
        ready = (DEPTH - m) >= FW;
        if (!ready) m_full++;
        if (m == 0) m_empty++;
        for (int k = 0; k < IW; k++) vm[k] = (k < m);
        n = lead_ones(acc & vm);
        if (fl) begin
            exp_q.delete();
        end else begin
            repeat (n) void'(exp_q.pop_front());
            if (ready) begin
                for (int l = 0; l < FW; l++) if (fv[l]) exp_q.push_back(lane[l]);
            end
        end
        tick();
        fetch_valid_i = '0;
        ib_accept_i   = '0;
        flush_i       = 1'b0;
        chk("count", 128'(count_o), 128'(exp_q.size()));
        check_perf();
    endtask

    // Sequential-PC push of the valid lanes; PCs advance only when the group is taken.
    task automatic push_seq(input logic [FW-1:0] fv, input logic [IW-1:0] acc);
        logic [31:0] p0;
        logic [31:0] p1;
        logic        ready;
        ready = (DEPTH - exp_q.size()) >= FW;
        p0 = next_pc;
        p1 = fv[0] ? next_pc + 32'd4 : next_pc;
        do_cycle(fv, p0, p1, 2'b00, 4'd0, 4'd0, acc, 1'b0);
        if (ready) next_pc = next_pc + 32'd4 * 32'(fv[0] + fv[1]);
    endtask

    initial begin
        int pushed;
        int it;
        logic [FW-1:0] fv;
        rst              = 1'b1;
        flush_i          = 1'b0;
        fetch_valid_i    = 2'b11;
        fetch_pc_i       = {32'h1C00_0004, 32'h1C00_0000};
        fetch_instr_i    = '0;
        fetch_excp_i     = '0;
        fetch_excp_num_i = '0;
        ib_accept_i      = '0;

        // Reset with a push pending: the push must be discarded.
        tick();
        tick();
        chk("rst_id_valid", 128'(id_valid_o), 128'(0));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_fetch_ready", 128'(fetch_ready_o), 128'(1));
        check_window();
        chk("rst_full_cycles", 128'(full_cycles_o), 128'(0));
        chk("rst_empty_cycles", 128'(empty_cycles_o), 128'(0));
        rst = 1'b0;

        do_cycle(2'b11, 32'h1C00_0000, 32'h1C00_0004, 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
        chk("first_push_valid", 128'(id_valid_o), 128'(2'b11));
        chk("first_push_pc", 128'(id_pc_o), 128'({32'h1C00_0004, 32'h1C00_0000}));
        chk("first_push_count", 128'(count_o), 128'(2));

        do_cycle(2'b00, 32'h0, 32'h0, 2'b00, 4'd0, 4'd0, 2'b01, 1'b0);
        chk("partial_count", 128'(count_o), 128'(1));
        chk("partial_slot0_pc", 128'(id_pc_o[31:0]), 128'(32'h1C00_0004));
        chk("partial_valid", 128'(id_valid_o), 128'(2'b01));

        do_cycle(2'b00, 32'h0, 32'h0, 2'b00, 4'd0, 4'd0, 2'b10, 1'b0);
        chk("illegal_accept_count", 128'(count_o), 128'(1));

        do_cycle(2'b00, 32'h0, 32'h0, 2'b00, 4'd0, 4'd0, 2'b01, 1'b0);

        // Lane 1 alone must land in slot 0 with its own exception fields.
        do_cycle(2'b10, 32'hDEAD_0000, 32'h2000_0010, 2'b10, 4'd3, 4'd5, 2'b00, 1'b0);
        chk("compact_pc", 128'(id_pc_o[31:0]), 128'(32'h2000_0010));
        chk("compact_excp", 128'(id_excp_o[0]), 128'(1));
        chk("compact_num", 128'(id_excp_num_o[3:0]), 128'(5));
        chk("compact_valid", 128'(id_valid_o), 128'(2'b01));
        do_cycle(2'b00, 32'h0, 32'h0, 2'b00, 4'd0, 4'd0, 2'b11, 1'b0);

        push_seq(2'b11, 2'b00);
        push_seq(2'b11, 2'b00);
        push_seq(2'b11, 2'b00);
        push_seq(2'b01, 2'b00);
        chk("full_count7", 128'(count_o), 128'(7));
        chk("full_not_ready", 128'(fetch_ready_o), 128'(0));
        push_seq(2'b11, 2'b00);
        chk("held_group_count", 128'(count_o), 128'(7));
        push_seq(2'b11, 2'b11);
        chk("held_pop_count", 128'(count_o), 128'(5));
        chk("held_pop_ready", 128'(fetch_ready_o), 128'(1));
        push_seq(2'b01, 2'b00);
        push_seq(2'b11, 2'b11);
        chk("push_pop_at6_count", 128'(count_o), 128'(6));

        pushed = 0;
        it     = 0;
        while (pushed < 40 && it < 400) begin
            fv = 2'($urandom_range(0, 3));
            if ((DEPTH - exp_q.size()) >= FW) pushed += int'(fv[0]) + int'(fv[1]);
            push_seq(fv, 2'($urandom_range(0, 3)));
            it++;
        end
        chk("stream_pushed_40", 128'(pushed >= 40), 128'(1));
        it = 0;
        while (exp_q.size() > 0 && it < 50) begin
            push_seq(2'b00, 2'b11);
            it++;
        end
        chk("stream_drained", 128'(count_o), 128'(0));

        push_seq(2'b11, 2'b00);
        push_seq(2'b11, 2'b00);
        push_seq(2'b01, 2'b00);
        chk("pre_flush_count", 128'(count_o), 128'(5));
        do_cycle(2'b11, 32'h4000_0000, 32'h4000_0004, 2'b00, 4'd0, 4'd0, 2'b11, 1'b1);
        chk("flush_count", 128'(count_o), 128'(0));
        chk("flush_valid", 128'(id_valid_o), 128'(0));
        chk("flush_ready", 128'(fetch_ready_o), 128'(1));
        push_seq(2'b00, 2'b00);
        push_seq(2'b00, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
